crc5_rx_check: RTL and testbench

- Receive-side partner of the transmit CRC5 generator.
- Takes the serial bit stream from the receive bit-unstuffer (LSB-first, PID first, CRC5 last) and reassembles the packet into a parallel register.
- Runs the CRC5 LFSR over every bit after the PID, including the received CRC bits, and checks the residue at end-of-packet.
- Reports packet, length, CRC status and PID-check status to the receive protocol handler.

---
 rtl/usb_crc_pkg.sv | 30 +++
 rtl/sipo_register_right.sv | 25 ++
 rtl/crc5_rx_check.sv | 120 ++++++++++++
 tb/tb_crc5_rx_check.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/usb_crc_pkg.sv
// Shared constants, FSM state type and CRC5 step function for the USB receive CRC checker.
package usb_crc_pkg;

  localparam int         PID_BITS         = 8;
  localparam logic [4:0] CRC5_INIT        = 5'b11111;
  localparam logic [4:0] CRC5_RESIDUE     = 5'b00000;
  localparam logic [4:0] CRC5_RESIDUE_INV = 5'b01100;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PID,
    ST_BODY,
    ST_REPORT
  } rx_state_e;

  typedef struct packed {
    logic crc_ok;
    logic pid_ok;
    logic len_err;
    logic ovf_err;
  } rx_flags_t;

  // One LFSR step, state ordered {x4,x3,x2,x1,x0}; polynomial x^5 + x^2 + 1.
  function automatic logic [4:0] crc5_step(input logic [4:0] s, input logic b);
    logic fb;
    fb = b ^ s[4];
    return {s[3], s[2], s[1] ^ fb, s[0], fb};
  endfunction

endpackage

// File: rtl/sipo_register_right.sv
// Serial-in register: bit din lands at position idx; clr wipes the register in the same cycle.
module sipo_register_right #(
  parameter int WIDTH = 100,
  parameter int IW    = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             we,
  input  logic [IW-1:0]    idx,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  // Clear and write may coincide: the write wins for its bit, all others go to 0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else begin
      if (clr) q <= '0;
      if (we)  q[idx] <= din;
    end
  end

endmodule

// File: rtl/crc5_rx_check.sv
// Receive CRC5 checker: reassembles an LSB-first packet and checks CRC5, PID and length at EOP.
// Define USB_INVERT_CRC_EN to expect a complemented CRC (residue 5'b01100 instead of 5'b00000).
module crc5_rx_check
  import usb_crc_pkg::*;
#(
  parameter  int MAX_BITS = 100,
  parameter  int MIN_BITS = 13,
  localparam int CW       = $clog2(MAX_BITS + 1)
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                rx_bit,
  input  logic                rx_valid,
  input  logic                rx_eop,
  output logic [MAX_BITS-1:0] pkt_out,
  output logic [CW-1:0]       pkt_len,
  output logic                pkt_valid,
  output logic                crc_ok,
  output logic                pid_ok,
  output logic                len_err,
  output logic                ovf_err
);

`ifdef USB_INVERT_CRC_EN
  localparam logic [4:0] RESIDUE = CRC5_RESIDUE_INV;
`else
  localparam logic [4:0] RESIDUE = CRC5_RESIDUE;
`endif

  rx_state_e     state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [4:0]    lfsr, lfsr_nxt;
  logic          ovf, ovf_nxt;
  logic          start, wr_en;
  logic [CW-1:0] wr_idx;
  rx_flags_t     flags_q, flags_now, flags_out;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      lfsr    <= '0;
      ovf     <= 1'b0;
      flags_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      lfsr  <= lfsr_nxt;
      ovf   <= ovf_nxt;
      if (start)                   flags_q <= '0;
      else if (state == ST_REPORT) flags_q <= flags_now;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    lfsr_nxt  = lfsr;
    ovf_nxt   = ovf;
    start     = 1'b0;
    wr_en     = 1'b0;
    wr_idx    = cnt;
    unique case (state)
      ST_IDLE: begin
        if (rx_valid) begin
          start     = 1'b1;
          wr_en     = 1'b1;
          wr_idx    = '0;
          cnt_nxt   = CW'(1);
          lfsr_nxt  = CRC5_INIT;
          ovf_nxt   = 1'b0;
          state_nxt = ST_PID;
        end
      end
      ST_PID, ST_BODY: begin
        if (rx_valid) begin
          // Count keeps running past capacity so the overflow length is visible, then pins.
          cnt_nxt = (cnt == CW'(MAX_BITS + 1)) ? cnt : cnt + 1'b1;
          if (cnt < CW'(MAX_BITS)) wr_en   = 1'b1;
          else                     ovf_nxt = 1'b1;
          if (state == ST_BODY)                lfsr_nxt  = crc5_step(lfsr, rx_bit);
          else if (cnt == CW'(PID_BITS - 1))   state_nxt = ST_BODY;
        end
        if (rx_eop) state_nxt = ST_REPORT;
      end
      ST_REPORT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    flags_now.len_err = (cnt < CW'(MIN_BITS));
    flags_now.ovf_err = ovf;
    flags_now.pid_ok  = (pkt_out[7:4] == ~pkt_out[3:0]);
    flags_now.crc_ok  = (lfsr == RESIDUE) && !flags_now.len_err && !ovf;
  end

  // Results are live during REPORT and frozen in flags_q afterwards.
  assign flags_out = (state == ST_REPORT) ? flags_now : flags_q;
  assign pkt_valid = (state == ST_REPORT);
  assign crc_ok    = flags_out.crc_ok;
  assign pid_ok    = flags_out.pid_ok;
  assign len_err   = flags_out.len_err;
  assign ovf_err   = flags_out.ovf_err;
  assign pkt_len   = cnt;

  sipo_register_right #(
    .WIDTH (MAX_BITS),
    .IW    (CW)
  ) u_sipo (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (start),
    .we      (wr_en),
    .idx     (wr_idx),
    .din     (rx_bit),
    .q       (pkt_out)
  );

endmodule

// File: tb/tb_crc5_rx_check.sv
// Directed bench for crc5_rx_check with an expected-result scoreboard popped on pkt_valid.
module tb_crc5_rx_check;

  localparam int MAXB = 100;
  localparam int CW   = $clog2(MAXB + 1);
`ifdef USB_INVERT_CRC_EN
  localparam bit INV = 1'b1;
`else
  localparam bit INV = 1'b0;
`endif

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic            rx_bit = 1'b0, rx_valid = 1'b0, rx_eop = 1'b0;
  logic [MAXB-1:0] pkt_out;
  logic [CW-1:0]   pkt_len;
  logic            pkt_valid, crc_ok, pid_ok, len_err, ovf_err;

  crc5_rx_check #(.MAX_BITS(MAXB), .MIN_BITS(13)) dut (
    .clock(clock), .reset_n(reset_n), .rx_bit(rx_bit), .rx_valid(rx_valid), .rx_eop(rx_eop),
    .pkt_out(pkt_out), .pkt_len(pkt_len), .pkt_valid(pkt_valid), .crc_ok(crc_ok),
    .pid_ok(pid_ok), .len_err(len_err), .ovf_err(ovf_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [MAXB-1:0] out;
    int              len;
    bit              crc, pid, lerr, ovf;
    int              eop_edge;
    string           tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %0h exp %0h", tag, got, want);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n && pkt_valid) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_pkt_valid: got 1 exp 0");
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk({e.tag, "/latency"}, cyc, e.eop_edge);
        chk({e.tag, "/pkt_out"}, pkt_out, e.out);
        chk({e.tag, "/pkt_len"}, pkt_len, e.len);
        chk({e.tag, "/crc_ok"},  crc_ok,  e.crc);
        chk({e.tag, "/pid_ok"},  pid_ok,  e.pid);
        chk({e.tag, "/len_err"}, len_err, e.lerr);
        chk({e.tag, "/ovf_err"}, ovf_err, e.ovf);
      end
    end
  end

  task automatic send(input logic [127:0] bits, input int n, input int s1_at, input int s1_len,
                      input int s2_at, input int s2_len, input bit eop_last, input bit collide,
                      input bit exp_crc, input bit exp_pid, input string tag);
    exp_t x;
    x.out  = '0;
    for (int i = 0; i < n && i < MAXB; i++) x.out[i] = bits[i];
    x.len  = (n > MAXB) ? MAXB + 1 : n;
    x.crc  = exp_crc;
    x.pid  = exp_pid;
    x.lerr = (n < 13);
    x.ovf  = (n > MAXB);
    x.tag  = tag;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      rx_valid = 1'b1;
      rx_bit   = bits[i];
      rx_eop   = eop_last && (i == n - 1);
      if (rx_eop) begin
        x.eop_edge = cyc + 1;
        exp_q.push_back(x);
      end
      if (i + 1 == s1_at) repeat (s1_len) begin
        @(negedge clock); rx_valid = 1'b0; rx_bit = 1'b1;
      end
      if (i + 1 == s2_at) repeat (s2_len) begin
        @(negedge clock); rx_valid = 1'b0; rx_bit = 1'b1;
      end
    end
    if (!eop_last) begin
      @(negedge clock);
      rx_valid   = 1'b0;
      rx_eop     = 1'b1;
      x.eop_edge = cyc + 1;
      exp_q.push_back(x);
    end
    @(negedge clock);
    rx_valid = collide;
    rx_bit   = 1'b1;
    rx_eop   = collide;
    @(negedge clock);
    rx_valid = 1'b0;
    rx_eop   = 1'b0;
    for (int k = 0; k < 8 && exp_q.size() != 0; k++) @(negedge clock);
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL %s/timeout: got %0d pending exp 0", tag, exp_q.size());
      exp_q.delete();
    end
    @(negedge clock);
    chk({tag, "/hold_valid"}, pkt_valid, 1'b0);
    chk({tag, "/hold_len"},   pkt_len,   x.len);
    chk({tag, "/hold_crc"},   crc_ok,    exp_crc);
  endtask

  initial begin
    logic [127:0] tok, ovf_bits;
    tok      = 128'h7A05E1;
    ovf_bits = {32'hDEADBEEF, 32'h12345678, 40'hA5A5A5A5A5, 24'h7A05E1};

    repeat (2) @(negedge clock);
    chk("reset/pkt_valid", pkt_valid, 1'b0);
    chk("reset/pkt_out",   pkt_out,   '0);
    chk("reset/pkt_len",   pkt_len,   '0);
    chk("reset/flags",     {crc_ok, pid_ok, len_err, ovf_err}, 4'b0000);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    send(tok,                 24, 0, 0, 0, 0, 1'b0, 1'b0, !INV, 1'b1, "good");
    send(tok ^ 128'h1000,     24, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, "bit12_flip");
    send(128'h7A05E2,         24, 0, 0, 0, 0, 1'b0, 1'b0, !INV, 1'b0, "bad_pid");
    send(tok,                 24, 9, 1, 20, 3, 1'b0, 1'b0, !INV, 1'b1, "stalls");
    send(tok,                 10, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, "short");
    send(ovf_bits,           105, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, "overflow");
    send(tok,                 24, 0, 0, 0, 0, 1'b1, 1'b0, !INV, 1'b1, "eop_with_bit");
    send(tok,                 24, 0, 0, 0, 0, 1'b0, 1'b1, !INV, 1'b1, "report_collide");
    send(128'h8205E1,         24, 0, 0, 0, 0, 1'b0, 1'b0, INV,  1'b1, "crc_inverted");

    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      rx_valid = 1'b1;
      rx_bit   = tok[i];
    end
    @(negedge clock);
    rx_valid = 1'b0;
    reset_n  = 1'b0;
    #1;
    chk("midreset/pkt_valid", pkt_valid, 1'b0);
    chk("midreset/pkt_out",   pkt_out,   '0);
    chk("midreset/pkt_len",   pkt_len,   '0);
    chk("midreset/flags",     {crc_ok, pid_ok, len_err, ovf_err}, 4'b0000);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    chk("midreset/idle_len", pkt_len, '0);
    send(tok,                 24, 0, 0, 0, 0, 1'b0, 1'b0, !INV, 1'b1, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
